// File: rtl/mod_99_8b_respond.sv
// mod_99_8b_respond: MAC Merge verify-protocol respond side, classifies received mPackets and requests respond mPackets
module mod_99_8b_respond #(
  parameter logic [7:0] SMD_V = 8'h07,
  parameter logic [7:0] SMD_R = 8'h19,
  parameter int MPKT_LEN = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_begin,
  input  logic             link_fail,
  input  logic             pEnable,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic [7:0]       rx_data,
  input  logic             rx_crc_ok,
  input  logic             tx_r_done,
  output logic [1:0]       state,
  output logic             send_r,
  output logic             rcv_v,
  output logic             rcv_r,
  output logic [CNT_W-1:0] respond_cnt
);
  typedef enum logic [1:0] {
    INIT_RESPOND    = 2'd0,
    WAIT_FOR_VERIFY = 2'd1,
    SEND_RESPOND    = 2'd2
  } state_e;
  localparam int LW = $clog2(MPKT_LEN + 2);
  localparam logic [LW-1:0] LEN  = LW'(MPKT_LEN);
  localparam logic [LW-1:0] LMAX = LW'(MPKT_LEN + 1);
  localparam logic [LW-1:0] ZEND = LW'(MPKT_LEN - 4);
  state_e           state_q, state_d;
  logic             send_r_q, send_r_d;
  logic             rcv_v_q, rcv_v_d;
  logic             rcv_r_q, rcv_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             open_q, open_d;
  logic [7:0]       smd_q, smd_d;
  logic [LW-1:0]    len_q, len_d;
  logic             zero_q, zero_d;
  logic             frc, valid, v_hit;
  logic [LW-1:0]    idx;
  always_comb begin
    frc = link_fail | ~pEnable;
    idx = (len_q == LMAX) ? LMAX : len_q + LW'(1);
    open_d = open_q;
    smd_d = smd_q;
    len_d = len_q;
    zero_d = zero_q;
    valid = 1'b0;
    if (rx_valid && rx_sof) begin
      open_d = !rx_eof;
      smd_d = rx_data;
      len_d = '0;
      zero_d = 1'b1;
    end else if (rx_valid && open_q) begin
      open_d = !rx_eof;
      len_d = idx;
      zero_d = zero_q & (idx > ZEND || rx_data == 8'h00);
      valid = rx_eof && idx == LEN && zero_d && rx_crc_ok;
    end
    open_d = open_d & ~frc;
    v_hit = valid && smd_q == SMD_V && !frc;
    rcv_r_d = valid && smd_q == SMD_R && !frc;
    state_d = state_q;
    send_r_d = send_r_q;
    cnt_d = cnt_q;
    rcv_v_d = rcv_v_q | v_hit;
    if (frc) begin
      state_d = INIT_RESPOND;
      send_r_d = 1'b0;
      rcv_v_d = 1'b0;
    end else if (state_q == INIT_RESPOND) begin
      state_d = WAIT_FOR_VERIFY;
    end else if (state_q == WAIT_FOR_VERIFY && rcv_v_q) begin
      state_d = SEND_RESPOND;
      send_r_d = 1'b1;
      rcv_v_d = v_hit;
      cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    end else if (state_q == SEND_RESPOND && tx_r_done) begin
      state_d = WAIT_FOR_VERIFY;
      send_r_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_begin) begin
      state_q <= INIT_RESPOND;
      send_r_q <= 1'b0;
      rcv_v_q <= 1'b0;
      rcv_r_q <= 1'b0;
      cnt_q <= '0;
      open_q <= 1'b0;
      smd_q <= '0;
      len_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      send_r_q <= send_r_d;
      rcv_v_q <= rcv_v_d;
      rcv_r_q <= rcv_r_d;
      cnt_q <= cnt_d;
      open_q <= open_d;
      smd_q <= smd_d;
      len_q <= len_d;
      zero_q <= zero_d;
    end
  end
  assign state = state_q;
  assign send_r = send_r_q;
  assign rcv_v = rcv_v_q;
  assign rcv_r = rcv_r_q;
  assign respond_cnt = cnt_q;
endmodule

// File: tb/tb_mod_99_8b_respond.sv
// tb_mod_99_8b_respond: directed self-checking bench for mod_99_8b_respond
module tb_mod_99_8b_respond;
  logic       clk = 1'b0;
  logic       reset_begin = 1'b1;
  logic       link_fail = 1'b0;
  logic       p_enable = 1'b1;
  logic       rx_valid = 1'b0;
  logic       rx_sof = 1'b0;
  logic       rx_eof = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_crc_ok = 1'b0;
  logic       tx_r_done = 1'b0;
  logic [1:0] state;
  logic       send_r, rcv_v, rcv_r;
  logic [1:0] respond_cnt;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mod_99_8b_respond #(.CNT_W(2)) dut (
    .clk(clk), .reset_begin(reset_begin), .link_fail(link_fail), .pEnable(p_enable),
    .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_data(rx_data),
    .rx_crc_ok(rx_crc_ok), .tx_r_done(tx_r_done), .state(state), .send_r(send_r),
    .rcv_v(rcv_v), .rcv_r(rcv_r), .respond_cnt(respond_cnt)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic frame(input logic [7:0] smd, input int n, input int bad, input logic crc,
                       input int lf_at, input int td_at);
    rx_valid = 1'b1;
    rx_sof = 1'b1;
    rx_eof = (n == 0);
    rx_data = smd;
    rx_crc_ok = crc;
    tick;
    rx_sof = 1'b0;
    for (int i = 1; i <= n; i++) begin
      rx_eof = (i == n);
      rx_data = (i == bad) ? 8'h5a : (i > 60 ? 8'hc3 : 8'h00);
      link_fail = (i == lf_at);
      tx_r_done = (i == td_at);
      tick;
      if (i == lf_at) begin
        chk("lf_state", state, 0);
        chk("lf_send", send_r, 0);
      end
    end
    rx_valid = 1'b0;
    rx_eof = 1'b0;
    link_fail = 1'b0;
    tx_r_done = 1'b0;
  endtask
  task automatic good(input logic [7:0] smd);
    frame(smd, 64, 0, 1'b1, 0, 0);
  endtask
  task automatic do_reset;
    reset_begin = 1'b1;
    tick;
    reset_begin = 1'b0;
    tick;
  endtask
  task automatic done_pulse;
    tx_r_done = 1'b1;
    tick;
    tx_r_done = 1'b0;
  endtask
  initial begin
    tick;
    chk("rst_state", state, 0);
    chk("rst_send", send_r, 0);
    chk("rst_rcv_v", rcv_v, 0);
    chk("rst_rcv_r", rcv_r, 0);
    chk("rst_cnt", respond_cnt, 0);
    reset_begin = 1'b0;
    tick;
    chk("init_to_wait", state, 1);
    good(8'h07);
    chk("t1_rcv_v", rcv_v, 1);
    chk("t1_state_eof1", state, 1);
    chk("t1_send_eof1", send_r, 0);
    tick;
    chk("t1_state", state, 2);
    chk("t1_send", send_r, 1);
    chk("t1_rcv_v_clr", rcv_v, 0);
    chk("t1_cnt", respond_cnt, 1);
    tick;
    chk("t1_send_hold", send_r, 1);
    done_pulse;
    chk("t1_done_state", state, 1);
    chk("t1_done_send", send_r, 0);
    tick;
    chk("t1_stay", state, 1);
    frame(8'h07, 64, 10, 1'b1, 0, 0);
    chk("t2_nonzero", rcv_v, 0);
    frame(8'h07, 63, 0, 1'b1, 0, 0);
    chk("t2_short", rcv_v, 0);
    frame(8'h07, 65, 0, 1'b1, 0, 0);
    chk("t2_long", rcv_v, 0);
    frame(8'h07, 64, 0, 1'b0, 0, 0);
    chk("t2_crc", rcv_v, 0);
    frame(8'h07, 0, 0, 1'b1, 0, 0);
    chk("t2_single", rcv_v, 0);
    good(8'h33);
    chk("t2_smd_v", rcv_v, 0);
    chk("t2_smd_r", rcv_r, 0);
    tick;
    chk("t2_state", state, 1);
    chk("t2_cnt", respond_cnt, 1);
    done_pulse;
    chk("t2_stray_done", state, 1);
    good(8'h19);
    chk("t3_rcv_r", rcv_r, 1);
    chk("t3_rcv_v", rcv_v, 0);
    tick;
    chk("t3_pulse", rcv_r, 0);
    chk("t3_send", send_r, 0);
    chk("t3_state", state, 1);
    do_reset;
    chk("t4_cnt0", respond_cnt, 0);
    good(8'h07);
    tick;
    chk("t4_state_a", state, 2);
    good(8'h07);
    chk("t4_pending", rcv_v, 1);
    chk("t4_still_send", state, 2);
    good(8'h07);
    chk("t4_merge", rcv_v, 1);
    done_pulse;
    chk("t4_ret_state", state, 1);
    chk("t4_ret_send", send_r, 0);
    chk("t4_ret_rcv_v", rcv_v, 1);
    tick;
    chk("t4_again", state, 2);
    chk("t4_again_send", send_r, 1);
    chk("t4_cnt2", respond_cnt, 2);
    chk("t4_rcv_v_clr", rcv_v, 0);
    done_pulse;
    tick;
    chk("t4_merged_one", state, 1);
    good(8'h07);
    tick;
    chk("t4_cnt3", respond_cnt, 3);
    good(8'h07);
    frame(8'h07, 64, 0, 1'b1, 0, 63);
    chk("same_edge_state", state, 2);
    chk("same_edge_rcv_v", rcv_v, 1);
    chk("same_edge_cnt_sat", respond_cnt, 3);
    done_pulse;
    chk("same_edge_ret", state, 1);
    tick;
    chk("same_edge_resend", state, 2);
    done_pulse;
    tick;
    chk("same_edge_idle", state, 1);
    do_reset;
    frame(8'h07, 64, 0, 1'b1, 30, 0);
    chk("t5_drop", rcv_v, 0);
    chk("t5_recover", state, 1);
    frame(8'h07, 64, 0, 1'b1, 64, 0);
    chk("t5_eof_drop", rcv_v, 0);
    tick;
    good(8'h07);
    tick;
    chk("t5_send", state, 2);
    link_fail = 1'b1;
    tick;
    link_fail = 1'b0;
    chk("t5_lf_state", state, 0);
    chk("t5_lf_send", send_r, 0);
    chk("t5_lf_cnt", respond_cnt, 1);
    tick;
    chk("t5_lf_wait", state, 1);
    tick;
    chk("t5_lf_idle", send_r, 0);
    p_enable = 1'b0;
    tick;
    chk("t5_pen_state", state, 0);
    p_enable = 1'b1;
    tick;
    chk("t5_pen_wait", state, 1);
    do_reset;
    repeat (5) begin
      good(8'h07);
      tick;
      done_pulse;
    end
    chk("t6_sat", respond_cnt, 3);
    reset_begin = 1'b1;
    tick;
    reset_begin = 1'b0;
    chk("t6_rst_cnt", respond_cnt, 0);
    chk("t6_rst_state", state, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
